// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, state codes and
// the datapath mux/ALU select values.
package cpu_ctrl_pkg;

   localparam logic [3:0] OP_AND  = 4'h0;
   localparam logic [3:0] OP_OR   = 4'h1;
   localparam logic [3:0] OP_XOR  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_SLT  = 4'h5;
   localparam logic [3:0] OP_SLL  = 4'h6;
   localparam logic [3:0] OP_SRL  = 4'h7;
   localparam logic [3:0] OP_DIV  = 4'h8;
   localparam logic [3:0] OP_MUL  = 4'h9;
   localparam logic [3:0] OP_LOAD = 4'hA;
   localparam logic [3:0] OP_STOR = 4'hB;
   localparam logic [3:0] OP_ADDI = 4'hC;
   localparam logic [3:0] OP_SUBI = 4'hD;
   localparam logic [3:0] OP_BEQ  = 4'hE;
   localparam logic [3:0] OP_B    = 4'hF;

   typedef enum logic [3:0] {
      S_RST     = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_MEMADR  = 4'd3,
      S_MEMRD   = 4'd4,
      S_MEMWB   = 4'd5,
      S_MEMWR   = 4'd6,
      S_REX     = 4'd7,
      S_DIVWAIT = 4'd8,
      S_RWB     = 4'd9,
      S_IEX     = 4'd10,
      S_IWB     = 4'd11,
      S_BEQ     = 4'd12,
      S_JMP     = 4'd13
   } state_e;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_OPF = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BOFF = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic is_rtype(input logic [3:0] op);
      return op <= OP_MUL;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle FSM (master) and the datapath (slave).
interface multicycle_ctrl_if;
   logic [3:0] op;
   logic       zero;
   logic       mem_ready;
   logic       div_done;
   logic       pcwrite;
   logic       branch;
   logic       iord;
   logic       memread;
   logic       memwrite;
   logic       irwrite;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic [1:0] pcsrc;
   logic       div_start;
   logic       instr_done;

   modport master (
      input  op, zero, mem_ready, div_done,
      output pcwrite, branch, iord, memread, memwrite, irwrite, regdst,
             memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc, div_start,
             instr_done
   );

   modport slave (
      output op, zero, mem_ready, div_done,
      input  pcwrite, branch, iord, memread, memwrite, irwrite, regdst,
             memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc, div_start,
             instr_done
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback
// for the 4-bit-opcode CPU, stalling on memory and divider handshakes.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
(
   input logic          clk,
   input logic          reset,
   multicycle_ctrl_if.master bus
);

   state_e state, next;
   logic   done_q;
   logic   done_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_RST;
         done_q <= 1'b0;
      end else begin
         state  <= next;
         done_q <= done_d;
      end
   end

   always_comb begin
      next           = state;
      bus.pcwrite    = 1'b0;
      bus.branch     = 1'b0;
      bus.iord       = 1'b0;
      bus.memread    = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regwrite   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = SRCB_REG;
      bus.aluop      = ALUOP_ADD;
      bus.pcsrc      = PCSRC_ALU;
      bus.div_start  = 1'b0;
      bus.instr_done = 1'b0;

      case (state)
         S_RST: next = S_FETCH;

         S_FETCH: begin
            bus.memread    = 1'b1;
            bus.alusrcb    = SRCB_ONE;
            // IR and PC+1 commit only on the cycle memory actually returns
            bus.irwrite    = bus.mem_ready;
            bus.pcwrite    = bus.mem_ready;
            bus.instr_done = done_q;
            if (bus.mem_ready) next = S_DECODE;
         end

         S_DECODE: begin
            bus.alusrcb = SRCB_BOFF;
            if (is_rtype(bus.op))                             next = S_REX;
            else if (bus.op == OP_LOAD || bus.op == OP_STOR) next = S_MEMADR;
            else if (bus.op == OP_ADDI || bus.op == OP_SUBI) next = S_IEX;
            else if (bus.op == OP_BEQ)                        next = S_BEQ;
            else                                              next = S_JMP;
         end

         S_MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
            next        = (bus.op == OP_LOAD) ? S_MEMRD : S_MEMWR;
         end

         S_MEMRD: begin
            bus.memread = 1'b1;
            bus.iord    = 1'b1;
            if (bus.mem_ready) next = S_MEMWB;
         end

         S_MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 1'b1;
            next         = S_FETCH;
         end

         S_MEMWR: begin
            bus.memwrite = 1'b1;
            bus.iord     = 1'b1;
            if (bus.mem_ready) next = S_FETCH;
         end

         S_REX: begin
            bus.alusrca = 1'b1;
            bus.aluop   = ALUOP_OPF;
            if (bus.op == OP_DIV) begin
               bus.div_start = 1'b1;
               next          = S_DIVWAIT;
            end else begin
               next = S_RWB;
            end
         end

         S_DIVWAIT: begin
            bus.alusrca = 1'b1;
            bus.aluop   = ALUOP_OPF;
            if (bus.div_done) next = S_RWB;
         end

         S_RWB: begin
            bus.regwrite = 1'b1;
            bus.regdst   = 1'b1;
            next         = S_FETCH;
         end

         S_IEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_IMM;
            bus.aluop   = (bus.op == OP_SUBI) ? ALUOP_SUB : ALUOP_ADD;
            next        = S_IWB;
         end

         S_IWB: begin
            bus.regwrite = 1'b1;
            next         = S_FETCH;
         end

         S_BEQ: begin
            bus.alusrca = 1'b1;
            bus.aluop   = ALUOP_SUB;
            bus.branch  = 1'b1;
            bus.pcsrc   = PCSRC_ALUOUT;
            next        = S_FETCH;
         end

         S_JMP: begin
            bus.pcwrite = 1'b1;
            bus.pcsrc   = PCSRC_JUMP;
            next        = S_FETCH;
         end

         default: next = S_RST;
      endcase
   end

   // Flag the first FETCH after a completed instruction; stalls clear it
   always_comb begin
      done_d = 1'b0;
      if (next == S_FETCH) begin
         case (state)
            S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BEQ, S_JMP: done_d = 1'b1;
            default: done_d = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks instruction sequences cycle by
// cycle and compares the full control word against hand-derived values.
module tb_multicycle_ctrl;
   import cpu_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   multicycle_ctrl_if bus();

   multicycle_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
      end
   endtask

   function automatic logic [17:0] obs();
      return {bus.pcwrite, bus.branch, bus.iord, bus.memread, bus.memwrite,
              bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca,
              bus.alusrcb, bus.aluop, bus.pcsrc, bus.div_start, bus.instr_done};
   endfunction

   // Expected control word per state, written out from the state table
   function automatic logic [17:0] exp_word(input state_e st, input logic [3:0] o,
                                            input logic mr, input logic done);
      logic pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, sa, ds;
      logic [1:0] sb, aop, psrc;
      {pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, sa, ds} = '0;
      sb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         S_FETCH:   begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
         S_DECODE:  sb = 2'b11;
         S_MEMADR:  begin sa = 1; sb = 2'b10; end
         S_MEMRD:   begin mrd = 1; iord = 1; end
         S_MEMWB:   begin rw = 1; m2r = 1; end
         S_MEMWR:   begin mwr = 1; iord = 1; end
         S_REX:     begin sa = 1; aop = 2'b10; ds = (o == 4'h8); end
         S_DIVWAIT: begin sa = 1; aop = 2'b10; end
         S_RWB:     begin rw = 1; rdst = 1; end
         S_IEX:     begin sa = 1; sb = 2'b10; aop = (o == 4'hD) ? 2'b01 : 2'b00; end
         S_IWB:     rw = 1;
         S_BEQ:     begin sa = 1; aop = 2'b01; br = 1; psrc = 2'b01; end
         S_JMP:     begin pcw = 1; psrc = 2'b10; end
         default:   ;
      endcase
      return {pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, psrc, ds,
              (st == S_FETCH) ? done : 1'b0};
   endfunction

   // One clock cycle: drive inputs, check outputs mid-cycle, advance
   task automatic cyc(input string tag, input logic [3:0] o, input logic z,
                      input logic mr, input logic dd, input state_e st, input logic done);
      bus.op = o; bus.zero = z; bus.mem_ready = mr; bus.div_done = dd;
      #1;
      chk(tag, 32'(obs()), 32'(exp_word(st, o, mr, done)));
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      bus.op = 4'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0; bus.div_done = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) cyc("rst_hold", 4'h0, 0, 1, 0, S_RST, 0);
      reset = 1'b0;
      cyc("rst_rel",    4'h0, 0, 1, 0, S_RST,   0);
      cyc("f0_stall",   4'h0, 0, 0, 0, S_FETCH, 0);
      cyc("f0_go",      4'h3, 0, 1, 0, S_FETCH, 0);

      // ADD
      cyc("add_dec",    4'h3, 0, 1, 0, S_DECODE, 0);
      cyc("add_rex",    4'h3, 0, 1, 0, S_REX,    0);
      cyc("add_rwb",    4'h3, 0, 1, 0, S_RWB,    0);
      cyc("add_done",   4'hA, 0, 1, 0, S_FETCH,  1);

      // LOAD with two memory wait cycles
      cyc("ld_dec",     4'hA, 0, 1, 0, S_DECODE, 0);
      cyc("ld_adr",     4'hA, 0, 1, 0, S_MEMADR, 0);
      cyc("ld_rd0",     4'hA, 0, 0, 0, S_MEMRD,  0);
      cyc("ld_rd1",     4'hA, 0, 0, 0, S_MEMRD,  0);
      cyc("ld_rd2",     4'hA, 0, 1, 0, S_MEMRD,  0);
      cyc("ld_wb",      4'hA, 0, 1, 0, S_MEMWB,  0);
      cyc("ld_done",    4'h8, 0, 1, 0, S_FETCH,  1);

      // DIV: stray div_done in REX is ignored, done on 5th DIVWAIT cycle
      cyc("div_dec",    4'h8, 0, 1, 0, S_DECODE, 0);
      cyc("div_rex",    4'h8, 0, 1, 1, S_REX,    0);
      for (int i = 0; i < 4; i++) cyc("div_wait", 4'h8, 0, 1, 0, S_DIVWAIT, 0);
      cyc("div_wlast",  4'h8, 0, 1, 1, S_DIVWAIT, 0);
      cyc("div_rwb",    4'h8, 0, 1, 0, S_RWB,    0);
      cyc("div_done",   4'hE, 1, 1, 0, S_FETCH,  1);

      // BEQ then B
      cyc("beq_dec",    4'hE, 1, 1, 0, S_DECODE, 0);
      cyc("beq_ex",     4'hE, 1, 1, 0, S_BEQ,    0);
      cyc("beq_done",   4'hF, 0, 1, 0, S_FETCH,  1);
      cyc("b_dec",      4'hF, 0, 1, 0, S_DECODE, 0);
      cyc("b_jmp",      4'hF, 0, 1, 0, S_JMP,    0);
      cyc("b_done",     4'hD, 0, 1, 0, S_FETCH,  1);

      // SUBI
      cyc("subi_dec",   4'hD, 0, 1, 0, S_DECODE, 0);
      cyc("subi_ex",    4'hD, 0, 1, 0, S_IEX,    0);
      cyc("subi_wb",    4'hD, 0, 1, 0, S_IWB,    0);
      cyc("subi_done",  4'hB, 0, 1, 0, S_FETCH,  1);

      // STORE with one wait, then fetch stalls clear instr_done
      cyc("st_dec",     4'hB, 0, 1, 0, S_DECODE, 0);
      cyc("st_adr",     4'hB, 0, 1, 0, S_MEMADR, 0);
      cyc("st_wr0",     4'hB, 0, 0, 0, S_MEMWR,  0);
      cyc("st_wr1",     4'hB, 0, 1, 0, S_MEMWR,  0);
      cyc("st_done",    4'hC, 0, 0, 0, S_FETCH,  1);
      cyc("f_stall",    4'hC, 0, 0, 0, S_FETCH,  0);
      cyc("f_go",       4'hC, 0, 1, 0, S_FETCH,  0);

      // ADDI
      cyc("addi_dec",   4'hC, 0, 1, 0, S_DECODE, 0);
      cyc("addi_ex",    4'hC, 0, 1, 0, S_IEX,    0);
      cyc("addi_wb",    4'hC, 0, 1, 0, S_IWB,    0);
      cyc("addi_done",  4'h0, 0, 1, 0, S_FETCH,  1);

      // AND (opcode 0 boundary of R-type range)
      cyc("and_dec",    4'h0, 0, 1, 0, S_DECODE, 0);
      cyc("and_rex",    4'h0, 0, 1, 0, S_REX,    0);
      cyc("and_rwb",    4'h0, 0, 1, 0, S_RWB,    0);
      cyc("and_done",   4'hB, 0, 1, 0, S_FETCH,  1);

      // STORE interrupted by reset during a memory stall
      cyc("st2_dec",    4'hB, 0, 1, 0, S_DECODE, 0);
      cyc("st2_adr",    4'hB, 0, 1, 0, S_MEMADR, 0);
      reset = 1'b1;
      cyc("st2_wrrst",  4'hB, 0, 0, 0, S_MEMWR,  0);
      cyc("st2_rst",    4'hB, 0, 1, 0, S_RST,    0);
      reset = 1'b0;
      cyc("st2_rst2",   4'hB, 0, 1, 0, S_RST,    0);
      cyc("st2_fetch",  4'h3, 0, 0, 0, S_FETCH,  0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
